exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
Parameters: none; widths fixed (data 32, alu_op 12 one-hot, dest 5).
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL: ds_to_es_valid in 1 decode holds valid instruction; ds_pc in 32; ds_alu_op in 12 one-hot ALU op; ds_alu_rj in 32 operand 1; ds_alu_rk in 32 operand 2 (immediate already shifted for lui).
REQ-004 SHALL: ds_dest in 5; ds_gr_we in 1; ds_mem_we in 1 store; ds_res_from_mem in 1 load; ds_mem_size in 2 (00 byte, 01 half, 10 word); ds_store_data in 32.
REQ-005 SHALL: es_allowin out 1 stage can accept; ms_allowin in 1 MEM can accept; flush in 1 kill stage contents.
REQ-006 SHALL: es_to_ms_valid out 1; es_pc out 32; es_result out 32 ALU result; es_dest out 5; es_gr_we out 1; es_res_from_mem out 1; es_mem_addr_lo out 2.
REQ-007 SHALL: data_sram_en out 1; data_sram_we out 4 byte strobes; data_sram_addr out 32; data_sram_wdata out 32.
REQ-008 SHALL: es_fwd_valid out 1; es_fwd_dest out 5; es_fwd_data out 32; es_load_use out 1.

Function
REQ-009 SHALL: one pipeline register set (es_valid plus all ds_* fields) feeding an internal instance of the 12-op one-hot ALU; es_result = ALU output, combinational from registered fields.
REQ-010 SHALL: es_ready_go = 1 (single-cycle execute); es_to_ms_valid = es_valid & es_ready_go.
REQ-011 SHALL: es_allowin = ~es_valid | (es_ready_go & ms_allowin).
REQ-012 SHALL: es_valid next = 0 if flush; else ds_to_es_valid if es_allowin; else hold.
REQ-013 SHALL: payload registers load only when ds_to_es_valid & es_allowin & ~flush; otherwise hold (stall keeps outputs stable).
REQ-014 SHALL: flush coincident with ds_to_es_valid: flush wins, instruction dropped, es_valid 0 next cycle.
REQ-015 SHALL: data_sram_en = es_valid & (es_mem_we | es_res_from_mem) & ms_allowin & ~flush; request issued exactly once, in the cycle the instruction moves to MEM.
REQ-016 SHALL: data_sram_addr = es_result; es_mem_addr_lo = es_result[1:0].
REQ-017 SHALL: data_sram_we = 0 unless es_mem_we & data_sram_en; byte: 4'b0001 << addr[1:0]; half: 4'b0011 << {addr[1],0} (addr[0] ignored); word: 4'b1111 (addr[1:0] ignored); size 11: 0.
REQ-018 SHALL: data_sram_wdata = byte replicated x4, half replicated x2, or full word, per es_mem_size.
REQ-019 SHALL: no misalignment exception; loads drive data_sram_we = 0.
REQ-020 SHALL: es_fwd_valid = es_valid & es_gr_we & (es_dest != 0); es_fwd_dest = es_dest; es_fwd_data = es_result.
REQ-021 SHALL: es_load_use = es_fwd_valid & es_res_from_mem (decode must stall on match).
REQ-022 SHALL: zero-latency throughput: one instruction per cycle when ms_allowin stays 1.

Reset
REQ-023 SHALL: during/after reset es_valid = 0, all payload registers 0, es_allowin = 1, es_to_ms_valid = 0, data_sram_en = 0, data_sram_we = 0, es_fwd_valid = 0.
REQ-024 SHALL: reset asserted mid-stall discards held instruction; no SRAM request issued in or after the reset cycle until a new instruction arrives.

Verification
REQ-025 SHALL: add rj=5, rk=7, dest=3, gr_we=1, ms_allowin=1 -> next cycle es_to_ms_valid=1, es_result=12, es_fwd_valid=1, es_fwd_dest=3.
REQ-026 SHALL: st.b rj+rk=0x1003, store_data=0xAABBCCDD -> data_sram_en=1, we=4'b1000, addr=0x1003, wdata=0xDDDDDDDD; st.h at 0x1002 -> we=4'b1100, wdata=0xCCDDCCDD.
REQ-027 SHALL: ms_allowin=0 for 3 cycles with valid instruction held -> es_allowin=0, outputs unchanged, data_sram_en=0; on ms_allowin=1 -> single request, next instruction accepted.
REQ-028 SHALL: flush with ds_to_es_valid=1 and valid load in stage -> data_sram_en=0 that cycle, es_valid=0 next cycle.
REQ-029 SHALL: load to dest=0 -> es_fwd_valid=0, es_load_use=0; load to dest=9 -> es_load_use=1.
REQ-030 SHALL: reset pulse asserted asynchronously mid-stall -> es_to_ms_valid drops to 0 before next clock edge.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: one pipeline register set feeding a 12-op one-hot ALU, plus
// data SRAM request generation, byte-strobe/lane formatting and forwarding.

module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);
  logic        op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
  logic        op_or, op_xor, op_sll, op_srl, op_sra, op_lui;
  logic [31:0] adder_b;
  logic [31:0] adder_sum;
  logic        adder_cout;
  logic        adder_cin;
  logic        slt_res, sltu_res;
  logic [31:0] sra_res;

  always_comb begin
    {op_lui, op_sra, op_srl, op_sll, op_xor, op_or,
     op_nor, op_and, op_sltu, op_slt, op_sub, op_add} = alu_op;

    // sub/slt/sltu share the adder: a + ~b + 1
    adder_cin = op_sub | op_slt | op_sltu;
    adder_b   = adder_cin ? ~alu_src2 : alu_src2;
    {adder_cout, adder_sum} = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, adder_cin};

    slt_res  = (alu_src1[31] & ~alu_src2[31])
             | (~(alu_src1[31] ^ alu_src2[31]) & adder_sum[31]);
    sltu_res = ~adder_cout;
    sra_res  = $signed(alu_src1) >>> alu_src2[4:0];

    alu_result = ({32{op_add | op_sub}} & adder_sum)
               | ({32{op_slt}}          & {31'd0, slt_res})
               | ({32{op_sltu}}         & {31'd0, sltu_res})
               | ({32{op_and}}          & (alu_src1 & alu_src2))
               | ({32{op_nor}}          & ~(alu_src1 | alu_src2))
               | ({32{op_or}}           & (alu_src1 | alu_src2))
               | ({32{op_xor}}          & (alu_src1 ^ alu_src2))
               | ({32{op_sll}}          & (alu_src1 << alu_src2[4:0]))
               | ({32{op_srl}}          & (alu_src1 >> alu_src2[4:0]))
               | ({32{op_sra}}          & sra_res)
               | ({32{op_lui}}          & alu_src2);
  end
endmodule

module exe_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_to_es_valid,
  input  logic [31:0] ds_pc,
  input  logic [11:0] ds_alu_op,
  input  logic [31:0] ds_alu_rj,
  input  logic [31:0] ds_alu_rk,
  input  logic [4:0]  ds_dest,
  input  logic        ds_gr_we,
  input  logic        ds_mem_we,
  input  logic        ds_res_from_mem,
  input  logic [1:0]  ds_mem_size,
  input  logic [31:0] ds_store_data,
  output logic        es_allowin,
  input  logic        ms_allowin,
  input  logic        flush,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic [31:0] es_result,
  output logic [4:0]  es_dest,
  output logic        es_gr_we,
  output logic        es_res_from_mem,
  output logic [1:0]  es_mem_addr_lo,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic        es_fwd_valid,
  output logic [4:0]  es_fwd_dest,
  output logic [31:0] es_fwd_data,
  output logic        es_load_use
);
  logic        es_valid_q,        es_valid_d;
  logic [31:0] es_pc_q,           es_pc_d;
  logic [11:0] es_alu_op_q,       es_alu_op_d;
  logic [31:0] es_alu_rj_q,       es_alu_rj_d;
  logic [31:0] es_alu_rk_q,       es_alu_rk_d;
  logic [4:0]  es_dest_q,         es_dest_d;
  logic        es_gr_we_q,        es_gr_we_d;
  logic        es_mem_we_q,       es_mem_we_d;
  logic        es_res_from_mem_q, es_res_from_mem_d;
  logic [1:0]  es_mem_size_q,     es_mem_size_d;
  logic [31:0] es_store_data_q,   es_store_data_d;

  logic        es_ready_go;
  logic        load_payload;
  logic [3:0]  we_mask;

  assign es_ready_go    = 1'b1;
  assign es_allowin     = ~es_valid_q | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid_q & es_ready_go;

  always_comb begin
    es_valid_d        = es_valid_q;
    es_pc_d           = es_pc_q;
    es_alu_op_d       = es_alu_op_q;
    es_alu_rj_d       = es_alu_rj_q;
    es_alu_rk_d       = es_alu_rk_q;
    es_dest_d         = es_dest_q;
    es_gr_we_d        = es_gr_we_q;
    es_mem_we_d       = es_mem_we_q;
    es_res_from_mem_d = es_res_from_mem_q;
    es_mem_size_d     = es_mem_size_q;
    es_store_data_d   = es_store_data_q;

    if (flush)           es_valid_d = 1'b0;
    else if (es_allowin) es_valid_d = ds_to_es_valid;

    load_payload = ds_to_es_valid & es_allowin & ~flush;
    if (load_payload) begin
      es_pc_d           = ds_pc;
      es_alu_op_d       = ds_alu_op;
      es_alu_rj_d       = ds_alu_rj;
      es_alu_rk_d       = ds_alu_rk;
      es_dest_d         = ds_dest;
      es_gr_we_d        = ds_gr_we;
      es_mem_we_d       = ds_mem_we;
      es_res_from_mem_d = ds_res_from_mem;
      es_mem_size_d     = ds_mem_size;
      es_store_data_d   = ds_store_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid_q        <= 1'b0;
      es_pc_q           <= '0;
      es_alu_op_q       <= '0;
      es_alu_rj_q       <= '0;
      es_alu_rk_q       <= '0;
      es_dest_q         <= '0;
      es_gr_we_q        <= 1'b0;
      es_mem_we_q       <= 1'b0;
      es_res_from_mem_q <= 1'b0;
      es_mem_size_q     <= '0;
      es_store_data_q   <= '0;
    end else begin
      es_valid_q        <= es_valid_d;
      es_pc_q           <= es_pc_d;
      es_alu_op_q       <= es_alu_op_d;
      es_alu_rj_q       <= es_alu_rj_d;
      es_alu_rk_q       <= es_alu_rk_d;
      es_dest_q         <= es_dest_d;
      es_gr_we_q        <= es_gr_we_d;
      es_mem_we_q       <= es_mem_we_d;
      es_res_from_mem_q <= es_res_from_mem_d;
      es_mem_size_q     <= es_mem_size_d;
      es_store_data_q   <= es_store_data_d;
    end
  end

  alu u_alu (
    .alu_op     (es_alu_op_q),
    .alu_src1   (es_alu_rj_q),
    .alu_src2   (es_alu_rk_q),
    .alu_result (es_result)
  );

  assign es_pc           = es_pc_q;
  assign es_dest         = es_dest_q;
  assign es_gr_we        = es_gr_we_q;
  assign es_res_from_mem = es_res_from_mem_q;
  assign es_mem_addr_lo  = es_result[1:0];

  // Request only on the handoff cycle so a stalled access is issued exactly once
  assign data_sram_en   = es_valid_q & (es_mem_we_q | es_res_from_mem_q) & ms_allowin & ~flush;
  assign data_sram_addr = es_result;

  always_comb begin
    case (es_mem_size_q)
      2'b00:   we_mask = 4'b0001 << es_result[1:0];
      2'b01:   we_mask = 4'b0011 << {es_result[1], 1'b0};
      2'b10:   we_mask = 4'b1111;
      default: we_mask = 4'b0000;
    endcase
    data_sram_we = (es_mem_we_q & data_sram_en) ? we_mask : 4'b0000;

    case (es_mem_size_q)
      2'b00:   data_sram_wdata = {4{es_store_data_q[7:0]}};
      2'b01:   data_sram_wdata = {2{es_store_data_q[15:0]}};
      default: data_sram_wdata = es_store_data_q;
    endcase
  end

  assign es_fwd_valid = es_valid_q & es_gr_we_q & (es_dest_q != 5'd0);
  assign es_fwd_dest  = es_dest_q;
  assign es_fwd_data  = es_result;
  assign es_load_use  = es_fwd_valid & es_res_from_mem_q;
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: expected MEM-handoff records are queued when an
// instruction is accepted and compared when the stage hands it to MEM.

module tb_exe_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ds_to_es_valid;
  logic [31:0] ds_pc;
  logic [11:0] ds_alu_op;
  logic [31:0] ds_alu_rj, ds_alu_rk;
  logic [4:0]  ds_dest;
  logic        ds_gr_we, ds_mem_we, ds_res_from_mem;
  logic [1:0]  ds_mem_size;
  logic [31:0] ds_store_data;
  logic        es_allowin, ms_allowin, flush;
  logic        es_to_ms_valid;
  logic [31:0] es_pc, es_result;
  logic [4:0]  es_dest;
  logic        es_gr_we, es_res_from_mem;
  logic [1:0]  es_mem_addr_lo;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        es_fwd_valid;
  logic [4:0]  es_fwd_dest;
  logic [31:0] es_fwd_data;
  logic        es_load_use;

  localparam logic [11:0] OP_ADD  = 12'h001, OP_SUB = 12'h002, OP_SLT = 12'h004,
                          OP_SLTU = 12'h008, OP_AND = 12'h010, OP_NOR = 12'h020,
                          OP_OR   = 12'h040, OP_XOR = 12'h080, OP_SLL = 12'h100,
                          OP_SRL  = 12'h200, OP_SRA = 12'h400, OP_LUI = 12'h800;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] wdata;
    logic [4:0]  dest;
    logic        gr_we;
    logic        rfm;
    logic        en;
    logic [3:0]  we;
  } exp_t;

  exp_t        sb[$];
  int          total  = 0;
  int          passed = 0;
  logic [31:0] pc_ctr = 32'h1c00_0000;

  exe_stage dut (
    .clk(clk), .reset(reset), .ds_to_es_valid(ds_to_es_valid), .ds_pc(ds_pc),
    .ds_alu_op(ds_alu_op), .ds_alu_rj(ds_alu_rj), .ds_alu_rk(ds_alu_rk),
    .ds_dest(ds_dest), .ds_gr_we(ds_gr_we), .ds_mem_we(ds_mem_we),
    .ds_res_from_mem(ds_res_from_mem), .ds_mem_size(ds_mem_size),
    .ds_store_data(ds_store_data), .es_allowin(es_allowin), .ms_allowin(ms_allowin),
    .flush(flush), .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc),
    .es_result(es_result), .es_dest(es_dest), .es_gr_we(es_gr_we),
    .es_res_from_mem(es_res_from_mem), .es_mem_addr_lo(es_mem_addr_lo),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .es_fwd_valid(es_fwd_valid), .es_fwd_dest(es_fwd_dest),
    .es_fwd_data(es_fwd_data), .es_load_use(es_load_use)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] alu_model(input logic [11:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_AND:  return a & b;
      OP_NOR:  return ~(a | b);
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return 32'($signed(a) >>> b[4:0]);
      default: return b;
    endcase
  endfunction

  task automatic drive(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest, input logic gr_we, input logic mem_we,
                       input logic rfm, input logic [1:0] size, input logic [31:0] sd);
    ds_to_es_valid  = 1'b1;
    ds_pc           = pc_ctr;
    pc_ctr          = pc_ctr + 32'd4;
    ds_alu_op       = op;
    ds_alu_rj       = a;
    ds_alu_rk       = b;
    ds_dest         = dest;
    ds_gr_we        = gr_we;
    ds_mem_we       = mem_we;
    ds_res_from_mem = rfm;
    ds_mem_size     = size;
    ds_store_data   = sd;
  endtask

  // Expected record built from what the bench itself is driving
  task automatic push_cur();
    exp_t e;
    e.pc     = ds_pc;
    e.result = alu_model(ds_alu_op, ds_alu_rj, ds_alu_rk);
    e.dest   = ds_dest;
    e.gr_we  = ds_gr_we;
    e.rfm    = ds_res_from_mem;
    e.en     = ds_mem_we | ds_res_from_mem;
    e.we     = 4'b0000;
    e.wdata  = ds_store_data;
    if (ds_mem_we) begin
      case (ds_mem_size)
        2'd0: begin e.we = 4'(1 << e.result[1:0]); e.wdata = ds_store_data[7:0] * 32'h0101_0101; end
        2'd1: begin e.we = e.result[1] ? 4'b1100 : 4'b0011; e.wdata = ds_store_data[15:0] * 32'h0001_0001; end
        2'd2: e.we = 4'b1111;
        default: e.we = 4'b0000;
      endcase
    end
    sb.push_back(e);
  endtask

  task automatic issue(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest, input logic gr_we, input logic mem_we,
                       input logic rfm, input logic [1:0] size, input logic [31:0] sd);
    drive(op, a, b, dest, gr_we, mem_we, rfm, size, sd);
    push_cur();
  endtask

  task automatic monitor();
    exp_t e;
    if (!flush && es_to_ms_valid && ms_allowin) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pc", es_pc, e.pc);
        chk("result", es_result, e.result);
        chk("sram_addr", data_sram_addr, e.result);
        chk("addr_lo", 32'(es_mem_addr_lo), 32'(e.result[1:0]));
        chk("dest", 32'(es_dest), 32'(e.dest));
        chk("gr_we", 32'(es_gr_we), 32'(e.gr_we));
        chk("res_from_mem", 32'(es_res_from_mem), 32'(e.rfm));
        chk("sram_en", 32'(data_sram_en), 32'(e.en));
        chk("sram_we", 32'(data_sram_we), 32'(e.we));
        if (e.we != 4'b0000) chk("sram_wdata", data_sram_wdata, e.wdata);
      end
    end
  endtask

  task automatic tick();
    #1;
    monitor();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ms_allowin = 1'b1; flush = 1'b0;
    ds_to_es_valid = 1'b0; ds_pc = '0; ds_alu_op = '0; ds_alu_rj = '0; ds_alu_rk = '0;
    ds_dest = '0; ds_gr_we = 1'b0; ds_mem_we = 1'b0; ds_res_from_mem = 1'b0;
    ds_mem_size = '0; ds_store_data = '0;

    @(negedge clk); #1;
    chk("rst_allowin", 32'(es_allowin), 32'd1);
    chk("rst_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
    chk("rst_sram_en", 32'(data_sram_en), 32'd0);
    chk("rst_sram_we", 32'(data_sram_we), 32'd0);
    chk("rst_fwd_valid", 32'(es_fwd_valid), 32'd0);
    chk("rst_pc", es_pc, 32'd0);
    chk("rst_result", es_result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // add 5+7 -> r3, then back-to-back ALU ops
    issue(OP_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0);
    tick();
    issue(OP_SUB, 32'd5, 32'd7, 5'd4, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0);
    #1;
    chk("add_to_ms_valid", 32'(es_to_ms_valid), 32'd1);
    chk("add_result", es_result, 32'd12);
    chk("add_fwd_valid", 32'(es_fwd_valid), 32'd1);
    chk("add_fwd_dest", 32'(es_fwd_dest), 32'd3);
    chk("add_fwd_data", es_fwd_data, 32'd12);
    chk("add_allowin", 32'(es_allowin), 32'd1);
    tick();
    issue(OP_SLT,  32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0); tick();
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0); tick();
    issue(OP_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0); tick();
    issue(OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd6, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0); tick();
    issue(OP_NOR,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd6, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0); tick();
    issue(OP_OR,   32'hF0F0_1234, 32'h0FF0_FF00, 5'd6, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0); tick();
    issue(OP_XOR,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd6, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0); tick();
    issue(OP_SLL,  32'h8000_0001, 32'd33, 5'd7, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0); tick();
    issue(OP_SRL,  32'h8000_0000, 32'd4, 5'd7, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0); tick();
    issue(OP_SRA,  32'h8000_0000, 32'd4, 5'd7, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0); tick();
    issue(OP_LUI,  32'h1234_5678, 32'hABCD_E000, 5'd8, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0); tick();

    // stores: byte/half/word lane formatting, size 11 writes nothing
    issue(OP_ADD, 32'h1000, 32'h3, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 32'hAABB_CCDD); tick();
    #1;
    chk("stb_we", 32'(data_sram_we), 32'h8);
    chk("stb_wdata", data_sram_wdata, 32'hDDDD_DDDD);
    issue(OP_ADD, 32'h1000, 32'h2, 5'd0, 1'b0, 1'b1, 1'b0, 2'd1, 32'hAABB_CCDD); tick();
    #1;
    chk("sth_we", 32'(data_sram_we), 32'hC);
    chk("sth_wdata", data_sram_wdata, 32'hCCDD_CCDD);
    issue(OP_ADD, 32'h1000, 32'h1, 5'd0, 1'b0, 1'b1, 1'b0, 2'd1, 32'h1122_3344); tick();
    issue(OP_ADD, 32'h1000, 32'h1, 5'd0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h1122_3344); tick();
    issue(OP_ADD, 32'h1000, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h1122_3344); tick();
    issue(OP_ADD, 32'h1000, 32'h2, 5'd0, 1'b0, 1'b1, 1'b0, 2'd3, 32'h1122_3344); tick();

    // loads: dest 0 never forwards, dest 9 raises load-use
    issue(OP_ADD, 32'h2000, 32'h4, 5'd0, 1'b1, 1'b0, 1'b1, 2'd2, 32'hFFFF_FFFF); tick();
    issue(OP_ADD, 32'h2000, 32'h8, 5'd9, 1'b1, 1'b0, 1'b1, 2'd2, 32'hFFFF_FFFF);
    #1;
    chk("ld0_fwd_valid", 32'(es_fwd_valid), 32'd0);
    chk("ld0_load_use", 32'(es_load_use), 32'd0);
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    chk("ld9_load_use", 32'(es_load_use), 32'd1);
    chk("ld9_fwd_dest", 32'(es_fwd_dest), 32'd9);
    chk("ld9_sram_we", 32'(data_sram_we), 32'd0);
    tick();

    // MEM backpressure: load held for 3 cycles, next instruction waits
    issue(OP_ADD, 32'h3000, 32'h10, 5'd4, 1'b1, 1'b0, 1'b1, 2'd2, 32'd0); tick();
    ms_allowin = 1'b0;
    drive(OP_OR, 32'h55, 32'hAA, 5'd10, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      chk("stall_allowin", 32'(es_allowin), 32'd0);
      chk("stall_sram_en", 32'(data_sram_en), 32'd0);
      chk("stall_result", es_result, 32'h3010);
      chk("stall_valid", 32'(es_to_ms_valid), 32'd1);
      tick();
    end
    ms_allowin = 1'b1;
    push_cur();
    #1;
    chk("release_allowin", 32'(es_allowin), 32'd1);
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    chk("release_next_result", es_result, 32'hFF);
    chk("release_next_sram_en", 32'(data_sram_en), 32'd0);
    tick();

    // flush with a new instruction offered: load killed, nothing accepted
    issue(OP_ADD, 32'h4000, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 2'd2, 32'd0); tick();
    drive(OP_ADD, 32'd1, 32'd1, 5'd11, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0);
    flush = 1'b1;
    #1;
    chk("flush_sram_en", 32'(data_sram_en), 32'd0);
    void'(sb.pop_front());
    tick();
    flush = 1'b0; ds_to_es_valid = 1'b0;
    #1;
    chk("flush_valid_next", 32'(es_to_ms_valid), 32'd0);
    chk("flush_fwd_valid", 32'(es_fwd_valid), 32'd0);
    tick();

    // asynchronous reset in the middle of a stalled store
    issue(OP_ADD, 32'h5000, 32'h4, 5'd0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hCAFE_F00D); tick();
    ds_to_es_valid = 1'b0;
    ms_allowin = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
    chk("arst_allowin", 32'(es_allowin), 32'd1);
    ms_allowin = 1'b1;
    #1;
    chk("arst_sram_en", 32'(data_sram_en), 32'd0);
    chk("arst_sram_we", 32'(data_sram_we), 32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_valid", 32'(es_to_ms_valid), 32'd0);
    chk("post_rst_sram_en", 32'(data_sram_en), 32'd0);
    tick();
    #1;
    chk("post_rst_idle_en", 32'(data_sram_en), 32'd0);

    issue(OP_ADD, 32'h6000, 32'h8, 5'd12, 1'b1, 1'b1, 1'b0, 2'd2, 32'h1234_5678); tick();
    ds_to_es_valid = 1'b0;
    tick();
    tick();

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
